// File: rtl/light_show_ctrl_if.sv
// Handshake bundle between the show sequencer and its driver/observer.
// The pause signal exists only when LSC_PAUSE_EN is defined.
interface light_show_ctrl_if;
    logic start;
    logic abort;
    logic button;
`ifdef LSC_PAUSE_EN
    logic pause;
`endif
    logic step;
    logic sel;
    logic conv_en;
    logic busy;
    logic done;

    modport master (
`ifdef LSC_PAUSE_EN
        output pause,
`endif
        output start, abort, button,
        input  step, sel, conv_en, busy, done
    );

    modport slave (
`ifdef LSC_PAUSE_EN
        input  pause,
`endif
        input  start, abort, button,
        output step, sel, conv_en, busy, done
    );
endinterface

// File: rtl/light_show_ctrl.sv
// Light-show sequencer: white phase, then N_STEPS timed colour strobes, then a done pulse.
// Optional timer freeze via the pause input when LSC_PAUSE_EN is defined.
module light_show_ctrl #(
    parameter int unsigned WHITE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned N_STEPS      = 6
) (
    input  logic              clk,
    input  logic              rst,
    light_show_ctrl_if.slave  bus
);

    localparam int unsigned TW = $clog2(HOLD_CYCLES);
    localparam int unsigned CW = $clog2(N_STEPS + 1);
    localparam int unsigned WW = (WHITE_CYCLES > 1) ? $clog2(WHITE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WHITE = 2'd1;
    localparam logic [1:0] S_CYCLE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [TW-1:0] T_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N_STEPS - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WHITE_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [WW-1:0] wcnt_q,  wcnt_d;
    logic          btn_q,   btn_d;
    logic          step_q,  step_d;
    logic          sel_q,   sel_d;
    logic          conv_q,  conv_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          frozen;

    always_comb begin
        frozen = 1'b0;
`ifdef LSC_PAUSE_EN
        frozen = bus.pause && ((state_q == S_WHITE) || (state_q == S_CYCLE));
`endif
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        btn_d   = bus.button;
        step_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                cnt_d   = '0;
                wcnt_d  = '0;
                if (bus.button && !btn_q) begin
                    step_d = 1'b1;
                end
                if (bus.start && !bus.abort) begin
                    state_d = S_WHITE;
                end
            end
            S_WHITE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else if (!frozen) begin
                    if (wcnt_q == W_LAST) begin
                        state_d = S_CYCLE;
                        wcnt_d  = '0;
                        timer_d = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_CYCLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    cnt_d   = '0;
                end else if (!frozen) begin
                    if (timer_q == T_LAST) begin
                        timer_d = '0;
                        if (cnt_q == C_LAST) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                cnt_d   = '0;
                wcnt_d  = '0;
            end
        endcase

        // Strobe is registered from next state so it lands in the cycle the timer sits at its last count.
        if ((state_d == S_CYCLE) && !frozen && (timer_d == T_LAST)) begin
            step_d = 1'b1;
        end

        sel_d  = (state_d == S_CYCLE);
        conv_d = (state_d == S_CYCLE);
        busy_d = (state_d == S_WHITE) || (state_d == S_CYCLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            btn_q   <= 1'b0;
            step_q  <= 1'b0;
            sel_q   <= 1'b0;
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            btn_q   <= btn_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
            conv_q  <= conv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.step    = step_q;
    assign bus.sel     = sel_q;
    assign bus.conv_en = conv_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
